wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//  Shares one Wishbone slave segment between the CPU data master (m0) and instruction master (m1).
//  Round-robin arbitration; decodes the 4 slave regions from addr[31:28] (0=SDRAM,1=UART,2=GPIO,3=flash).
//  Lightweight replacement for the full crossbar; one transfer in flight; bus-error on bad address/timeout.
// PARAMETERS
//  TIMEOUT   1023  cycles in BUSY without slave ack before err is returned
//  CNT_W     10    width of timeout counter (must hold TIMEOUT)
// PORTS
//  clk        in   1    system clock
//  rst        in   1    asynchronous reset, active-low
//  m_cyc_i    in   2    master cycle, bit i = master i
//  m_stb_i    in   2    master strobe
//  m_we_i     in   2    master write enable
//  m_sel_i    in   8    byte selects, [4i+3:4i] = master i
//  m_addr_i   in   64   addresses, [32i+31:32i] = master i
//  m_data_i   in   64   write data, [32i+31:32i] = master i
//  m_data_o   out  32   read data, broadcast to both masters
//  m_ack_o    out  2    transfer ack to master i
//  m_err_o    out  2    bus error to master i
//  s_cyc_o    out  4    slave cycle, one-hot
//  s_stb_o    out  4    slave strobe, one-hot
//  s_we_o     out  1    shared write enable
//  s_sel_o    out  4    shared byte selects
//  s_addr_o   out  32   shared address (unmodified master address)
//  s_data_o   out  32   shared write data
//  s_data_i   in   128  slave read data, [32j+31:32j] = slave j
//  s_ack_i    in   4    slave ack
// BEHAVIOUR
//  - req[i] = m_cyc_i[i] & m_stb_i[i]. FSM states IDLE, BUSY, ERRACK; regs gnt (1b), last (1b), cnt.
//  - Reset: state=IDLE, gnt=0, last=1 (m0 wins first tie), cnt=0; all outputs 0.
//  - IDLE: no req -> stay. One req -> gnt=that master. Both -> gnt=~last. Go BUSY next cycle.
//  - BUSY: slave index j=m_addr[gnt][31:28]. j<=3: s_cyc_o[j]/s_stb_o[j] = m_cyc/m_stb of gnt;
//    s_we/sel/addr/data from gnt master, combinational. Other slave strobes 0.
//  - BUSY, s_ack_i[j]=1: m_ack_o[gnt]=1 same cycle, m_data_o=s_data_i[j]; last<=gnt; -> IDLE.
//  - BUSY, j>3 (decode miss): no slave strobed; -> ERRACK next cycle.
//  - BUSY, cnt reaches TIMEOUT with no ack: slave strobes dropped; -> ERRACK.
//  - ERRACK: m_err_o[gnt]=1 for exactly one cycle, no slave strobed, m_ack_o=0; last<=gnt; -> IDLE.
//  - cnt: cleared in IDLE/ERRACK, +1 each BUSY cycle without ack; saturates, never wraps.
//  - Master drops m_cyc_i[gnt] in BUSY: slave cyc/stb fall same cycle; -> IDLE, no ack/err, last<=gnt.
//  - m_data_o = 0 outside BUSY-with-ack. Ack/err never to the non-granted master.
//  - Latency: req at cycle N -> slave stb at N+1; slave ack at M -> master ack at M; IDLE at M+1;
//    earliest next slave stb at M+2 (one idle bubble between transfers, by design).
//  - Non-granted master's req held pending; round-robin bounds its wait to one transfer of the other.
//  - Async reset mid-transfer: all strobes/acks drop immediately; FSM restarts in IDLE.
// TESTING
//  1 m0 reads 0x1000_0004, UART acks after 2 cycles with 0xA5 -> s_stb_o=4'b0010 at N+1, m_ack_o=2'b01, m_data_o=0xA5.
//  2 m0,m1 request same cycle after reset (SDRAM, flash) -> m0 served first, then m1 (s_stb_o 0001 then 1000).
//  3 both hold req continuously for 4 transfers -> grants alternate m0,m1,m0,m1; one idle cycle between.
//  4 m1 addresses 0x5000_0000 -> no s_stb_o, m_err_o=2'b10 for one cycle, FSM back in IDLE.
//  5 TIMEOUT=8, GPIO never acks -> m_err_o[gnt] pulses once 9 cycles after stb, s_stb_o drops.
//  6 rst low while SDRAM transfer in BUSY -> all outputs 0 asynchronously; after release, new req granted normally.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter: two masters (m0 data, m1 instruction) share four slaves decoded from addr[31:28].
// Latency: request to slave strobe 1 cycle; slave ack to master ack 0 cycles; one idle bubble between transfers.
// Backpressure: the losing master's request is held pending; at most one transfer is in flight; bad decode or timeout returns err.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i   per-master Wishbone controls (bit i = master i)
//   m_sel_i/m_addr_i/m_data_i per-master select/address/write data, packed by master index
//   m_data_o/m_ack_o/m_err_o read data (shared), per-master ack and error
//   s_cyc_o/s_stb_o          one-hot slave cycle/strobe
//   s_we_o/s_sel_o/s_addr_o/s_data_o  shared slave controls taken from the granted master
//   s_data_i/s_ack_i         per-slave read data and ack
module wb_bus_arbiter #(
   parameter int TIMEOUT = 1023,
   parameter int CNT_W   = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     m_cyc_i,
   input  logic [1:0]     m_stb_i,
   input  logic [1:0]     m_we_i,
   input  logic [7:0]     m_sel_i,
   input  logic [63:0]    m_addr_i,
   input  logic [63:0]    m_data_i,
   output logic [31:0]    m_data_o,
   output logic [1:0]     m_ack_o,
   output logic [1:0]     m_err_o,
   output logic [3:0]     s_cyc_o,
   output logic [3:0]     s_stb_o,
   output logic           s_we_o,
   output logic [3:0]     s_sel_o,
   output logic [31:0]    s_addr_o,
   output logic [31:0]    s_data_o,
   input  logic [127:0]   s_data_i,
   input  logic [3:0]     s_ack_i
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY   = 2'd1,
      S_ERRACK = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic             r_gnt, w_gnt_nxt;
   logic             r_last, w_last_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   logic [1:0]       w_req;
   logic [31:0]      w_addr;
   logic [3:0]       w_region;
   logic             w_hit;
   logic [1:0]       w_slv;
   logic             w_gcyc;
   logic             w_gstb;
   logic             w_tmo;
   logic             w_sack;
   logic [31:0]      w_sdat;
   logic [1:0]       w_gnt_oh;

   assign w_req    = m_cyc_i & m_stb_i;
   assign w_addr   = r_gnt ? m_addr_i[63:32] : m_addr_i[31:0];
   assign w_region = w_addr[31:28];
   assign w_hit    = (w_region[3:2] == 2'b00);
   assign w_slv    = w_region[1:0];
   assign w_gcyc   = m_cyc_i[r_gnt];
   assign w_gstb   = m_stb_i[r_gnt];
   assign w_tmo    = (r_cnt >= CNT_W'(TIMEOUT));
   assign w_sack   = s_ack_i[w_slv];
   assign w_sdat   = s_data_i[{w_slv, 5'd0} +: 32];
   assign w_gnt_oh = r_gnt ? 2'b10 : 2'b01;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_gnt   <= 1'b0;
         r_last  <= 1'b1;   // m0 wins the first tie
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      m_data_o    = '0;
      m_ack_o     = '0;
      m_err_o     = '0;
      s_cyc_o     = '0;
      s_stb_o     = '0;
      s_we_o      = 1'b0;
      s_sel_o     = '0;
      s_addr_o    = '0;
      s_data_o    = '0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (|w_req) begin
               w_gnt_nxt   = (w_req == 2'b11) ? ~r_last : w_req[1];
               w_state_nxt = S_BUSY;
            end
         end

         S_BUSY: begin
            s_we_o   = m_we_i[r_gnt];
            s_sel_o  = m_sel_i[{r_gnt, 2'b00} +: 4];
            s_addr_o = w_addr;
            s_data_o = m_data_i[{r_gnt, 5'd0} +: 32];
            if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
            if (!w_gcyc) begin
               // master abandoned the cycle: release without ack or err
               w_last_nxt  = r_gnt;
               w_state_nxt = S_IDLE;
            end else if (!w_hit || w_tmo) begin
               // decode miss or no ack in time: keep slaves quiet, report err next cycle
               w_state_nxt = S_ERRACK;
            end else begin
               s_cyc_o = 4'b0001 << w_slv;
               s_stb_o = w_gstb ? (4'b0001 << w_slv) : 4'b0000;
               if (w_sack) begin
                  m_ack_o     = w_gnt_oh;
                  m_data_o    = w_sdat;
                  w_cnt_nxt   = r_cnt;
                  w_last_nxt  = r_gnt;
                  w_state_nxt = S_IDLE;
               end
            end
         end

         S_ERRACK: begin
            m_err_o     = w_gnt_oh;
            w_cnt_nxt   = '0;
            w_last_nxt  = r_gnt;
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;

   logic           clk;
   logic           rst;
   logic [1:0]     m_cyc_i;
   logic [1:0]     m_stb_i;
   logic [1:0]     m_we_i;
   logic [7:0]     m_sel_i;
   logic [63:0]    m_addr_i;
   logic [63:0]    m_data_i;
   logic [31:0]    m_data_o;
   logic [1:0]     m_ack_o;
   logic [1:0]     m_err_o;
   logic [3:0]     s_cyc_o;
   logic [3:0]     s_stb_o;
   logic           s_we_o;
   logic [3:0]     s_sel_o;
   logic [31:0]    s_addr_o;
   logic [31:0]    s_data_o;
   logic [127:0]   s_data_i;
   logic [3:0]     s_ack_i;

   int checks;
   int errors;

   wb_bus_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .m_cyc_i  (m_cyc_i),
      .m_stb_i  (m_stb_i),
      .m_we_i   (m_we_i),
      .m_sel_i  (m_sel_i),
      .m_addr_i (m_addr_i),
      .m_data_i (m_data_i),
      .m_data_o (m_data_o),
      .m_ack_o  (m_ack_o),
      .m_err_o  (m_err_o),
      .s_cyc_o  (s_cyc_o),
      .s_stb_o  (s_stb_o),
      .s_we_o   (s_we_o),
      .s_sel_o  (s_sel_o),
      .s_addr_o (s_addr_o),
      .s_data_o (s_data_o),
      .s_data_i (s_data_i),
      .s_ack_i  (s_ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        do_rst;
      logic [1:0]  cyc;
      logic [1:0]  stb;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [3:0]  ack;
      logic [31:0] sd;
      logic [3:0]  e_cyc;
      logic [3:0]  e_stb;
      logic [1:0]  e_ack;
      logic [1:0]  e_err;
      logic [31:0] e_dat;
   } vec_t;

   vec_t vt[32];

   function automatic vec_t mk(logic r, logic [1:0] cyc, logic [1:0] stb, logic [31:0] a0,
                               logic [31:0] a1, logic [3:0] ack, logic [31:0] sd,
                               logic [3:0] e_cyc, logic [3:0] e_stb, logic [1:0] e_ack,
                               logic [1:0] e_err, logic [31:0] e_dat);
      vec_t v;
      v.do_rst = r;   v.cyc = cyc;     v.stb = stb;     v.a0 = a0;       v.a1 = a1;
      v.ack = ack;    v.sd = sd;       v.e_cyc = e_cyc; v.e_stb = e_stb;
      v.e_ack = e_ack; v.e_err = e_err; v.e_dat = e_dat;
      return v;
   endfunction

   // Acking slave lanes carry sd; idle lanes carry a tag so a wrong read mux shows up.
   function automatic logic [127:0] sdata(logic [3:0] ack, logic [31:0] sd);
      logic [127:0] d;
      for (int j = 0; j < 4; j++) begin
         d[32*j +: 32] = ack[j] ? sd : (32'hDEAD_0000 | 32'(j));
      end
      return d;
   endfunction

   function automatic logic [63:0] out_ctl();
      return {20'd0, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_data_o};
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_ctl(input string nm, input logic [3:0] cyc, input logic [3:0] stb,
                          input logic [1:0] ack, input logic [1:0] err, input logic [31:0] dat);
      check(nm, out_ctl(), {20'd0, cyc, stb, ack, err, dat});
   endtask

   task automatic chk_all_zero(input string nm);
      check({nm, "_ctl"}, out_ctl(), 64'd0);
      check({nm, "_pt"}, {s_we_o, s_sel_o, s_addr_o, s_data_o}, 64'd0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b0;
      m_cyc_i  = '0;
      m_stb_i  = '0;
      m_we_i   = '0;
      m_sel_i  = '0;
      m_addr_i = '0;
      m_data_i = '0;
      s_ack_i  = '0;
      s_data_i = sdata(4'b0000, 32'd0);

      //        rst  cyc    stb    a0             a1             ack      sd             e_cyc    e_stb    e_ack  e_err  e_dat
      // single m0 read from UART, ack after two wait cycles
      vt[0]  = mk(0, 2'b01, 2'b01, 32'h1000_0004, 32'h0,         4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[1]  = mk(0, 2'b01, 2'b01, 32'h1000_0004, 32'h0,         4'b0000, 32'h0,         4'b0010, 4'b0010, 2'b00, 2'b00, 32'h0);
      vt[2]  = mk(0, 2'b01, 2'b01, 32'h1000_0004, 32'h0,         4'b0000, 32'h0,         4'b0010, 4'b0010, 2'b00, 2'b00, 32'h0);
      vt[3]  = mk(0, 2'b01, 2'b01, 32'h1000_0004, 32'h0,         4'b0010, 32'hA5,        4'b0010, 4'b0010, 2'b01, 2'b00, 32'hA5);
      vt[4]  = mk(0, 2'b00, 2'b00, 32'h0,         32'h0,         4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      // simultaneous requests straight after reset: m0 (SDRAM) then m1 (flash)
      vt[5]  = mk(1, 2'b11, 2'b11, 32'h0000_0000, 32'h3000_0000, 4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[6]  = mk(0, 2'b11, 2'b11, 32'h0000_0000, 32'h3000_0000, 4'b0001, 32'h1111_1111, 4'b0001, 4'b0001, 2'b01, 2'b00, 32'h1111_1111);
      vt[7]  = mk(0, 2'b10, 2'b10, 32'h0000_0000, 32'h3000_0000, 4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[8]  = mk(0, 2'b10, 2'b10, 32'h0000_0000, 32'h3000_0000, 4'b1000, 32'h2222_2222, 4'b1000, 4'b1000, 2'b10, 2'b00, 32'h2222_2222);
      vt[9]  = mk(0, 2'b00, 2'b00, 32'h0,         32'h0,         4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      // both masters hold requests: grants alternate m0 (GPIO), m1 (SDRAM) with one idle cycle each
      vt[10] = mk(0, 2'b11, 2'b11, 32'h2000_0010, 32'h0000_0020, 4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[11] = mk(0, 2'b11, 2'b11, 32'h2000_0010, 32'h0000_0020, 4'b0100, 32'h3333_0000, 4'b0100, 4'b0100, 2'b01, 2'b00, 32'h3333_0000);
      vt[12] = mk(0, 2'b11, 2'b11, 32'h2000_0010, 32'h0000_0020, 4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[13] = mk(0, 2'b11, 2'b11, 32'h2000_0010, 32'h0000_0020, 4'b0001, 32'h4444_0000, 4'b0001, 4'b0001, 2'b10, 2'b00, 32'h4444_0000);
      vt[14] = mk(0, 2'b11, 2'b11, 32'h2000_0010, 32'h0000_0020, 4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[15] = mk(0, 2'b11, 2'b11, 32'h2000_0010, 32'h0000_0020, 4'b0100, 32'h5555_0000, 4'b0100, 4'b0100, 2'b01, 2'b00, 32'h5555_0000);
      vt[16] = mk(0, 2'b11, 2'b11, 32'h2000_0010, 32'h0000_0020, 4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[17] = mk(0, 2'b11, 2'b11, 32'h2000_0010, 32'h0000_0020, 4'b0001, 32'h6666_0000, 4'b0001, 4'b0001, 2'b10, 2'b00, 32'h6666_0000);
      vt[18] = mk(0, 2'b00, 2'b00, 32'h0,         32'h0,         4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      // m1 decode miss: no strobe, single-cycle err
      vt[19] = mk(0, 2'b10, 2'b10, 32'h0,         32'h5000_0000, 4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[20] = mk(0, 2'b10, 2'b10, 32'h0,         32'h5000_0000, 4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[21] = mk(0, 2'b00, 2'b00, 32'h0,         32'h0,         4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b10, 32'h0);
      vt[22] = mk(0, 2'b00, 2'b00, 32'h0,         32'h0,         4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      // m0 abandons its cycle mid-transfer: strobes fall the same cycle, no ack/err
      vt[23] = mk(0, 2'b01, 2'b01, 32'h1000_0000, 32'h0,         4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[24] = mk(0, 2'b01, 2'b01, 32'h1000_0000, 32'h0,         4'b0000, 32'h0,         4'b0010, 4'b0010, 2'b00, 2'b00, 32'h0);
      vt[25] = mk(0, 2'b00, 2'b00, 32'h1000_0000, 32'h0,         4'b0010, 32'hBAD,       4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[26] = mk(0, 2'b00, 2'b00, 32'h0,         32'h0,         4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      // m0 holds cyc but drops stb for a cycle (wait state on the master side)
      vt[27] = mk(0, 2'b01, 2'b01, 32'h3000_0000, 32'h0,         4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[28] = mk(0, 2'b01, 2'b01, 32'h3000_0000, 32'h0,         4'b0000, 32'h0,         4'b1000, 4'b1000, 2'b00, 2'b00, 32'h0);
      vt[29] = mk(0, 2'b01, 2'b00, 32'h3000_0000, 32'h0,         4'b0000, 32'h0,         4'b1000, 4'b0000, 2'b00, 2'b00, 32'h0);
      vt[30] = mk(0, 2'b01, 2'b01, 32'h3000_0000, 32'h0,         4'b1000, 32'h77,        4'b1000, 4'b1000, 2'b01, 2'b00, 32'h77);
      vt[31] = mk(0, 2'b00, 2'b00, 32'h0,         32'h0,         4'b0000, 32'h0,         4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);

      // reset state, checked while reset is asserted and again after release
      #11;
      chk_all_zero("reset_held");
      rst = 1'b1;
      #2;
      chk_all_zero("reset_released");

      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         m_cyc_i  = vt[i].cyc;
         m_stb_i  = vt[i].stb;
         m_addr_i = {vt[i].a1, vt[i].a0};
         s_ack_i  = vt[i].ack;
         s_data_i = sdata(vt[i].ack, vt[i].sd);
         if (vt[i].do_rst) begin
            rst = 1'b0;
            #1;
            rst = 1'b1;
         end
         #2;
         chk_ctl($sformatf("vec%0d", i), vt[i].e_cyc, vt[i].e_stb, vt[i].e_ack, vt[i].e_err, vt[i].e_dat);
      end

      // timeout: m1 writes to GPIO which never acks (TIMEOUT=8 in this bench)
      @(negedge clk);
      m_cyc_i  = 2'b10;
      m_stb_i  = 2'b10;
      m_we_i   = 2'b10;
      m_sel_i  = {4'b1100, 4'b0011};
      m_addr_i = {32'h2000_0008, 32'h1000_0000};
      m_data_i = {32'hCAFE_BABE, 32'h1234_5678};
      s_ack_i  = 4'b0000;
      s_data_i = sdata(4'b0000, 32'h0);
      #2;
      chk_ctl("tmo_req", 4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (k == 10) begin
            m_cyc_i = 2'b00;
            m_stb_i = 2'b00;
         end
         #2;
         chk_ctl($sformatf("tmo_k%0d", k),
                 (k <= 8) ? 4'b0100 : 4'b0000,
                 (k <= 8) ? 4'b0100 : 4'b0000,
                 2'b00,
                 (k == 10) ? 2'b10 : 2'b00,
                 32'h0);
         if (k == 1) begin
            check("tmo_passthru", {s_we_o, s_sel_o, s_addr_o, s_data_o},
                  {1'b1, 4'b1100, 32'h2000_0008, 32'hCAFE_BABE});
         end
      end
      m_we_i   = '0;
      m_sel_i  = '0;
      m_data_i = '0;

      // asynchronous reset in the middle of an SDRAM transfer
      @(negedge clk);
      m_cyc_i  = 2'b01;
      m_stb_i  = 2'b01;
      m_addr_i = {32'h0, 32'h0000_0100};
      #2;
      chk_ctl("arst_req", 4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      @(negedge clk);
      s_ack_i  = 4'b0001;
      s_data_i = sdata(4'b0001, 32'hABCD_0001);
      #1;
      chk_ctl("arst_busy", 4'b0001, 4'b0001, 2'b01, 2'b00, 32'hABCD_0001);
      rst = 1'b0;
      #1;
      chk_all_zero("arst_async");
      @(negedge clk);
      m_cyc_i  = 2'b10;
      m_stb_i  = 2'b10;
      m_addr_i = {32'h3000_0040, 32'h0};
      s_ack_i  = 4'b0000;
      s_data_i = sdata(4'b0000, 32'h0);
      #1;
      rst = 1'b1;
      #1;
      chk_ctl("arst_idle", 4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);
      @(negedge clk);
      s_ack_i  = 4'b1000;
      s_data_i = sdata(4'b1000, 32'h0000_0099);
      #2;
      chk_ctl("arst_regrant", 4'b1000, 4'b1000, 2'b10, 2'b00, 32'h0000_0099);
      @(negedge clk);
      m_cyc_i = 2'b00;
      m_stb_i = 2'b00;
      s_ack_i = 4'b0000;
      #2;
      chk_ctl("arst_done", 4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
